pulse_sync_rx: RTL and testbench

Multi-channel receive-side pulse synchroniser for the `clk_b` domain. Each of `NUM_CH` asynchronous, source-stretched level inputs goes through a `SYNC_STAGES`-deep synchroniser and a configurable edge detector. The block then emits a one-cycle `pulse_out` per detected edge. Detected events are also collected into a sticky event vector with a valid/ready handshake and per-channel saturating merge counters, so a slow consumer never loses an event and can see how many events were coalesced.

---
 rtl/pulse_sync_rx.sv | 91 +++++++++
 tb/tb_pulse_sync_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_rx.sv
// Multi-channel pulse synchroniser for the clk_b domain with sticky events and merge counters.
// Optional glitch filter on the synchronised level: define PULSE_SYNC_FILTER_EN.
module pulse_sync_rx #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                    clk_b,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       async_in,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [NUM_CH-1:0]       evt_vec,
  output logic [NUM_CH*CNT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_CH-1:0] sync [SYNC_STAGES];
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] lvl_d;
  logic [NUM_CH-1:0] pend;
  logic [CNT_W-1:0]  cnt [NUM_CH];
  logic              accept;

  // Synchroniser shift chain
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync[s] <= '0;
    end else begin
      sync[0] <= async_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync[s] <= sync[s-1];
    end
  end

`ifdef PULSE_SYNC_FILTER_EN
  logic [NUM_CH-1:0] diff;
  assign diff = sync[SYNC_STAGES-1] ^ sync[SYNC_STAGES-2];

  // Level only follows once the last two stages agree, rejecting one-cycle bounces
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) lvl <= '0;
    else        lvl <= (sync[SYNC_STAGES-1] & ~diff) | (lvl & diff);
  end
`else
  assign lvl = sync[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) lvl_d <= '0;
    else        lvl_d <= lvl;
  end

  always_comb begin
    pulse_out = lvl & ~lvl_d;
    case (EDGE_MODE)
      1:       pulse_out = ~lvl & lvl_d;
      2:       pulse_out = lvl ^ lvl_d;
      default: pulse_out = lvl & ~lvl_d;
    endcase
  end

  assign accept = evt_valid & evt_ready;

  // Accept reloads from the current pulses so a same-cycle edge is never dropped
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt[i] <= '0;
    end else begin
      pend <= accept ? pulse_out : (pend | pulse_out);
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (accept)
          cnt[i] <= CNT_W'(pulse_out[i]);
        else if (pulse_out[i] && (cnt[i] != CNT_MAX))
          cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign evt_vec   = pend;
  assign evt_valid = |pend;

  always_comb begin
    evt_cnt = '0;
    for (int i = 0; i < int'(NUM_CH); i++) evt_cnt[i*CNT_W +: CNT_W] = cnt[i];
  end

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Bench for pulse_sync_rx: three instances (rise/fall/both) against a history-based model.
module tb_pulse_sync_rx;

  localparam int S   = 2;
  localparam int MAX = 15;
`ifdef PULSE_SYNC_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  localparam int HOLD = S + 1 + FILT;

  logic        clk_b = 1'b0;
  logic        rst_n;
  logic [3:0]  ain;
  logic        rdy;
  logic [3:0]  po [3];
  logic        vl [3];
  logic [3:0]  ev [3];
  logic [15:0] ec [3];

  int errors = 0;
  int checks = 0;

  always #5 clk_b = ~clk_b;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pulse_sync_rx #(.NUM_CH(4), .SYNC_STAGES(S), .EDGE_MODE(g), .CNT_W(4)) dut (
      .clk_b(clk_b), .rst_n(rst_n), .async_in(ain), .pulse_out(po[g]),
      .evt_valid(vl[g]), .evt_ready(rdy), .evt_vec(ev[g]), .evt_cnt(ec[g])
    );
  end

  // Model: sampled-input history, level history, and per-mode pending/count state
  logic [3:0] samp [$];
  logic [3:0] lvl_cur, lvl_prev;
  logic [3:0] m_pend [3];
  int         m_cnt  [3][4];

  function automatic logic [3:0] hist(int idx);
    return (idx >= 0 && idx < samp.size()) ? samp[idx] : 4'b0;
  endfunction

  function automatic logic [3:0] pf(int m, logic [3:0] l, logic [3:0] ld);
    if (m == 0) return l & ~ld;
    if (m == 1) return ~l & ld;
    return l ^ ld;
  endfunction

  task automatic model_reset();
    samp.delete();
    lvl_cur = '0;
    lvl_prev = '0;
    for (int m = 0; m < 3; m++) begin
      m_pend[m] = '0;
      for (int i = 0; i < 4; i++) m_cnt[m][i] = 0;
    end
  endtask

  task automatic model_edge(logic [3:0] a, logic r);
    int k;
    logic [3:0] p, s1, s2, d, nl;
    for (int m = 0; m < 3; m++) begin
      p = pf(m, lvl_cur, lvl_prev);
      if (r && m_pend[m] != 0) begin
        m_pend[m] = p;
        for (int i = 0; i < 4; i++) m_cnt[m][i] = p[i] ? 1 : 0;
      end else begin
        m_pend[m] = m_pend[m] | p;
        for (int i = 0; i < 4; i++) if (p[i] && m_cnt[m][i] < MAX) m_cnt[m][i]++;
      end
    end
    k  = samp.size();
    s1 = hist(k - S);
    s2 = hist(k - S + 1);
    d  = s1 ^ s2;
    nl = (FILT != 0) ? ((s1 & ~d) | (lvl_cur & d)) : s2;
    samp.push_back(a);
    lvl_prev = lvl_cur;
    lvl_cur  = nl;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] e;
    for (int m = 0; m < 3; m++) begin
      e = '0;
      for (int i = 0; i < 4; i++) e[i*4 +: 4] = 4'(m_cnt[m][i]);
      chk($sformatf("pulse_out m%0d", m), 32'(po[m]), 32'(pf(m, lvl_cur, lvl_prev)));
      chk($sformatf("evt_vec m%0d", m), 32'(ev[m]), 32'(m_pend[m]));
      chk($sformatf("evt_valid m%0d", m), 32'(vl[m]), 32'(m_pend[m] != 0));
      chk($sformatf("evt_cnt m%0d", m), 32'(ec[m]), 32'(e));
    end
  endtask

  task automatic check_zero(string tag);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s pulse m%0d", tag, m), 32'(po[m]), 32'd0);
      chk($sformatf("%s valid m%0d", tag, m), 32'(vl[m]), 32'd0);
      chk($sformatf("%s vec m%0d", tag, m), 32'(ev[m]), 32'd0);
      chk($sformatf("%s cnt m%0d", tag, m), 32'(ec[m]), 32'd0);
    end
  endtask

  task automatic tick(logic [3:0] a, logic r);
    ain = a;
    rdy = r;
    @(posedge clk_b);
    model_edge(a, r);
    #1;
    check_all();
  endtask

  task automatic do_reset(logic [3:0] a);
    @(negedge clk_b);
    #1 rst_n = 1'b0;
    ain = a;
    rdy = 1'b0;
    #1 check_zero("reset");
    model_reset();
    repeat (2) @(posedge clk_b);
    @(negedge clk_b);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, pc;
    int hold [4];
    logic [3:0] a;
    rst_n = 1'b0;
    ain = '0;
    rdy = 1'b0;
    model_reset();
    #12 check_zero("por");
    @(negedge clk_b);
    rst_n = 1'b1;

    // Single rise on ch1
    tick(4'b0010, 0);
    repeat (1 + FILT) tick(4'b0010, 0);
    chk("single pulse", 32'(po[0]), 32'h2);
    tick(4'b0010, 0);
    chk("single vec", 32'(ev[0]), 32'h2);
    chk("single cnt", 32'(ec[0][7:4]), 32'd1);
    repeat (2) tick(4'b0000, 0);
    tick(4'b0000, 1);
    chk("single accepted", 32'(vl[0]), 32'd0);
    repeat (8) tick(4'b0000, 1);

    // Both-edge mode, 5-cycle high phase on ch0
    pc = 0;
    repeat (5) begin tick(4'b0001, 0); pc += int'(po[2][0]); end
    repeat (6) begin tick(4'b0000, 0); pc += int'(po[2][0]); end
    chk("both pulses", 32'(pc), 32'd2);
    chk("both cnt", 32'(ec[2][3:0]), 32'd2);
    chk("both vec", 32'(ev[2]), 32'h1);
    repeat (8) tick(4'b0000, 1);

    // Saturation: 20 rising edges on ch3 with no accept
    repeat (20) begin
      repeat (4) tick(4'b1000, 0);
      repeat (4) tick(4'b0000, 0);
    end
    chk("sat cnt", 32'(ec[0][15:12]), 32'd15);
    chk("sat pend", 32'(ev[0][3]), 32'd1);
    repeat (8) tick(4'b0000, 1);

    // Edge arriving in the accept cycle
    repeat (4) tick(4'b0100, 0);
    repeat (4) tick(4'b0000, 0);
    chk("acc pend pre", 32'(ev[0][2]), 32'd1);
    n = 0;
    tick(4'b0100, 0);
    while (!po[0][2] && n < 8) begin tick(4'b0100, 0); n++; end
    chk("acc pulse seen", 32'(po[0][2]), 32'd1);
    tick(4'b0100, 1);
    chk("acc vec", 32'(ev[0][2]), 32'd1);
    chk("acc cnt", 32'(ec[0][11:8]), 32'd1);
    chk("acc valid", 32'(vl[0]), 32'd1);
    repeat (8) tick(4'b0000, 1);

    // Build counts 3 (ch1) and 5 (ch3), then reset mid-operation
    for (int j = 0; j < 5; j++) begin
      repeat (4) tick({1'b1, 1'b0, (j < 3), 1'b0}, 0);
      repeat (4) tick(4'b0000, 0);
    end
    chk("pre-rst vec", 32'(ev[0]), 32'ha);
    chk("pre-rst cnt1", 32'(ec[0][7:4]), 32'd3);
    chk("pre-rst cnt3", 32'(ec[0][15:12]), 32'd5);
    do_reset(4'b0000);
    repeat (6) tick(4'b0000, 0);

    // Input high across reset release produces one rising edge
    do_reset(4'b0001);
    repeat (6) tick(4'b0001, 0);
    chk("rel rise cnt", 32'(ec[0][3:0]), 32'd1);
    repeat (6) tick(4'b0000, 1);

    // Single-cycle glitch on ch0
    pc = 0;
    tick(4'b0001, 0);
    pc += int'(po[0][0]);
    repeat (6) begin tick(4'b0000, 0); pc += int'(po[0][0]); end
`ifdef PULSE_SYNC_FILTER_EN
    chk("glitch filtered", 32'(pc), 32'd0);
`else
    chk("glitch passed", 32'(pc), 32'd1);
`endif
    repeat (4) tick(4'b0000, 1);

    // Randomised levels honouring the hold contract, random ready
    a = '0;
    for (int i = 0; i < 4; i++) hold[i] = HOLD;
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          if ($urandom_range(1, 0) == 1) begin
            a[i] = ~a[i];
            hold[i] = int'($urandom_range(HOLD + 4, HOLD)) - 1;
          end
        end else hold[i]--;
      end
      tick(a, ($urandom_range(3, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
